// File: rtl/sdram_cmd_arbiter_if.sv
// Command-port bundle between the two requesters, the arbiter and the
// SDRAM control interface.
interface sdram_cmd_arbiter_if #(
  parameter int ASIZE = 23
);
  logic             p0_req;
  logic             p0_wr;
  logic [ASIZE-1:0] p0_addr;
  logic             p0_gnt;
  logic             p1_req;
  logic             p1_wr;
  logic [ASIZE-1:0] p1_addr;
  logic             p1_gnt;
  logic [1:0]       cmd;
  logic [ASIZE-1:0] cmd_addr;
  logic             cmdack;
  logic             ref_pending;

  modport master (
    output p0_req, p0_wr, p0_addr,
    output p1_req, p1_wr, p1_addr,
    output cmdack,
    input  p0_gnt, p1_gnt,
    input  cmd, cmd_addr, ref_pending
  );

  modport slave (
    input  p0_req, p0_wr, p0_addr,
    input  p1_req, p1_wr, p1_addr,
    input  cmdack,
    output p0_gnt, p1_gnt,
    output cmd, cmd_addr, ref_pending
  );
endinterface

// File: rtl/sdram_cmd_arbiter.sv
// SDRAM command-port scheduler: periodic auto-refresh has priority,
// two user ports are served round-robin, commands held until cmdack.
module sdram_cmd_arbiter #(
  parameter int ASIZE      = 23,
  parameter int REF_PERIOD = 1560,
  parameter int MAX_DEBT   = 4
) (
  input logic               clk,
  input logic               reset,
  sdram_cmd_arbiter_if.slave bus
);

  localparam int TW = (REF_PERIOD > 2) ? $clog2(REF_PERIOD) : 1;
  localparam int DW = $clog2(MAX_DEBT + 1);

  localparam logic [TW-1:0] T_LOAD = TW'(REF_PERIOD - 1);
  localparam logic [DW-1:0] D_MAX  = DW'(MAX_DEBT);

  localparam logic [1:0] C_NOP = 2'b00;
  localparam logic [1:0] C_RD  = 2'b01;
  localparam logic [1:0] C_WR  = 2'b10;
  localparam logic [1:0] C_REF = 2'b11;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t           state;
  logic [TW-1:0]    ref_timer;
  logic [DW-1:0]    ref_debt;
  logic             rr_last;
  logic             owner;
  logic             is_ref;
  logic [1:0]       cmd_q;
  logic [ASIZE-1:0] addr_q;
  logic             g0_q;
  logic             g1_q;

  logic tick;
  logic pend;
  logic debt_inc;
  logic debt_dec;
  logic pick0;
  logic pick1;
  logic acked;

  assign tick  = (ref_timer == '0);
  assign pend  = (ref_debt != '0);
  assign acked = (state == BUSY) && bus.cmdack;

  // Saturated debt drops new ticks; a tick paired with an ack nets out.
  assign debt_inc = tick && (ref_debt != D_MAX);
  assign debt_dec = acked && is_ref;

  // rr_last==1 means p1 was served last, so p0 wins a tie.
  assign pick0 = !pend && bus.p0_req &&
                 (!bus.p1_req || rr_last);
  assign pick1 = !pend && bus.p1_req &&
                 (!bus.p0_req || !rr_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_timer <= T_LOAD;
      ref_debt  <= '0;
    end else begin
      ref_timer <= tick ? T_LOAD : ref_timer - TW'(1);
      if (debt_inc && !debt_dec)
        ref_debt <= ref_debt + DW'(1);
      else if (debt_dec && !debt_inc)
        ref_debt <= ref_debt - DW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cmd_q   <= C_NOP;
      addr_q  <= '0;
      g0_q    <= 1'b0;
      g1_q    <= 1'b0;
      rr_last <= 1'b1;
      owner   <= 1'b0;
      is_ref  <= 1'b0;
    end else begin
      g0_q <= 1'b0;
      g1_q <= 1'b0;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            pend: begin
              cmd_q  <= C_REF;
              addr_q <= '0;
              is_ref <= 1'b1;
              state  <= BUSY;
            end
            pick0: begin
              cmd_q  <= bus.p0_wr ? C_WR : C_RD;
              addr_q <= bus.p0_addr;
              owner  <= 1'b0;
              is_ref <= 1'b0;
              state  <= BUSY;
            end
            pick1: begin
              cmd_q  <= bus.p1_wr ? C_WR : C_RD;
              addr_q <= bus.p1_addr;
              owner  <= 1'b1;
              is_ref <= 1'b0;
              state  <= BUSY;
            end
            default: begin
              cmd_q  <= C_NOP;
              addr_q <= '0;
            end
          endcase
        end
        BUSY: begin
          if (bus.cmdack) begin
            cmd_q  <= C_NOP;
            addr_q <= '0;
            state  <= IDLE;
            if (!is_ref) begin
              g0_q    <= !owner;
              g1_q    <= owner;
              rr_last <= owner;
            end
          end
        end
      endcase
    end
  end

  assign bus.cmd         = cmd_q;
  assign bus.cmd_addr    = addr_q;
  assign bus.p0_gnt      = g0_q;
  assign bus.p1_gnt      = g1_q;
  assign bus.ref_pending = pend;

endmodule
